// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter: FSM state encoding and width helper.
package arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ARB   = 2'd1,
        ARB_GRANT = 2'd2
    } arb_state_e;

    // Bit width needed to index n items, never less than one bit.
    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set request strictly after last_grant, wrapping.
module rr_pick
    import arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     last_grant,
    output logic               found,
    output logic [IDW-1:0]     winner
);

    localparam int DW = 2 * NUM_REQ;

    logic [DW-1:0] dbl_req;
    logic [DW-1:0] mask;
    logic [DW-1:0] masked;
    logic [DW-1:0] lowest;

    // The upper copy of req guarantees a hit within NUM_REQ positions of the
    // mask start whenever any request is set, so no upper bound is needed.
    assign dbl_req = {req, req};
    assign mask    = {DW{1'b1}} << (int'(last_grant) + 1);
    assign masked  = dbl_req & mask;
    assign lowest  = masked & (~masked + DW'(1));
    assign found   = |req;

    always_comb begin
        winner = '0;
        for (int p = 0; p < DW; p++) begin
            if (lowest[p]) winner = IDW'(p % NUM_REQ);
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter with optional hold limit; all outputs decoded from registers.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter  int NUM_REQ  = 4,
    parameter  int MAX_HOLD = 8,
    localparam int IDW      = clog2_min1(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] granted_req,
    output logic               grant_valid,
    output logic [IDW-1:0]     grant_id,
    output logic               preempt
);

    localparam int HCW       = clog2_min1(MAX_HOLD);
    localparam int HOLD_LAST = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

    arb_state_e         state_q, state_d;
    logic [IDW-1:0]     cur_id_q, cur_id_d;
    logic [IDW-1:0]     last_grant_q, last_grant_d;
    logic [HCW-1:0]     hold_cnt_q, hold_cnt_d;
    logic               preempt_q, preempt_d;

    logic               pick_found;
    logic [IDW-1:0]     pick_winner;
    logic [NUM_REQ-1:0] cur_onehot;
    logic               cur_valid;
    logic               others;
    logic               hold_full;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req        (req),
        .last_grant (last_grant_q),
        .found      (pick_found),
        .winner     (pick_winner)
    );

    assign cur_onehot = NUM_REQ'(1) << cur_id_q;
    assign cur_valid  = int'(cur_id_q) < NUM_REQ;
    assign others     = |(req & ~cur_onehot);
    assign hold_full  = hold_cnt_q == HCW'(HOLD_LAST);

    always_comb begin
        state_d      = state_q;
        cur_id_d     = cur_id_q;
        last_grant_d = last_grant_q;
        hold_cnt_d   = hold_cnt_q;
        preempt_d    = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (|req) state_d = ARB_ARB;
            end
            ARB_ARB: begin
                if (pick_found) begin
                    state_d      = ARB_GRANT;
                    cur_id_d     = pick_winner;
                    last_grant_d = pick_winner;
                    hold_cnt_d   = '0;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_GRANT: begin
                if (!cur_valid) begin
                    state_d  = ARB_IDLE;
                    cur_id_d = '0;
                end else if (!(|(req & cur_onehot))) begin
                    state_d = others ? ARB_ARB : ARB_IDLE;
                end else if ((MAX_HOLD != 0) && hold_full && others) begin
                    state_d   = ARB_ARB;
                    preempt_d = 1'b1;
                end else if (!hold_full) begin
                    hold_cnt_d = hold_cnt_q + HCW'(1);
                end
            end
            default: begin
                state_d  = ARB_IDLE;
                cur_id_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            cur_id_q     <= '0;
            last_grant_q <= IDW'(NUM_REQ - 1);
            hold_cnt_q   <= '0;
            preempt_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_id_q     <= cur_id_d;
            last_grant_q <= last_grant_d;
            hold_cnt_q   <= hold_cnt_d;
            preempt_q    <= preempt_d;
        end
    end

    // An out-of-range cur_id never produces a grant, even for the one cycle before recovery.
    assign grant_valid = (state_q == ARB_GRANT) && cur_valid;
    assign granted_req = grant_valid ? cur_onehot : '0;
    assign grant_id    = grant_valid ? cur_id_q : '0;
    assign preempt     = preempt_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: per-cycle model comparison on two configurations plus directed literals.
module tb_rr_arbiter;

    localparam int N     = 4;
    localparam int MH    = 4;
    localparam int IDW   = 2;
    localparam int BOUND = (N - 1) * (MH + 1) + 2;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   g_a, g_b;
    logic           v_a, v_b;
    logic [IDW-1:0] id_a, id_b;
    logic           p_a, p_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rr_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
        .clk(clk), .reset(reset), .req(req),
        .granted_req(g_a), .grant_valid(v_a), .grant_id(id_a), .preempt(p_a)
    );

    rr_arbiter #(.NUM_REQ(N), .MAX_HOLD(0)) dut0 (
        .clk(clk), .reset(reset), .req(req),
        .granted_req(g_b), .grant_valid(v_b), .grant_id(id_b), .preempt(p_b)
    );

    // Model: phase 0 idle, 1 arbitrating, 2 granting; run = grant cycles served so far.
    int m_ph[2], m_own[2], m_last[2], m_run[2];
    bit m_pre[2];
    bit m_ok = 1'b0;

    task automatic model_step(input int k, input int mh);
        logic [N-1:0] oth;
        if (reset) begin
            m_ph[k] = 0; m_last[k] = N - 1; m_run[k] = 0; m_pre[k] = 1'b0; m_own[k] = 0;
        end else begin
            m_pre[k] = 1'b0;
            case (m_ph[k])
                0: if (req != 0) m_ph[k] = 1;
                1: begin
                    m_ph[k] = 0;
                    for (int off = 1; off <= N; off++) begin
                        int c;
                        c = (m_last[k] + off) % N;
                        if (m_ph[k] == 0 && req[c]) begin
                            m_ph[k] = 2; m_own[k] = c; m_last[k] = c; m_run[k] = 1;
                        end
                    end
                end
                default: begin
                    oth = req;
                    oth[m_own[k]] = 1'b0;
                    if (!req[m_own[k]]) m_ph[k] = (oth != 0) ? 1 : 0;
                    else if (mh != 0 && m_run[k] >= mh && oth != 0) begin
                        m_ph[k] = 1; m_pre[k] = 1'b1;
                    end else if (m_run[k] < mh) m_run[k]++;
                end
            endcase
        end
    endtask

    function automatic logic [7:0] mexp(input int k);
        logic [N-1:0] g;
        logic [IDW-1:0] id;
        g  = (m_ph[k] == 2) ? (4'b0001 << m_own[k]) : 4'b0000;
        id = (m_ph[k] == 2) ? IDW'(m_own[k]) : '0;
        return {g, m_ph[k] == 2, id, m_pre[k]};
    endfunction

    initial forever begin
        @(posedge clk);
        model_step(0, MH);
        model_step(1, 0);
        m_ok = 1'b1;
    end

    task automatic cmp(input int k, input logic [7:0] act);
        logic [7:0] e;
        e = mexp(k);
        checks++;
        if (act !== e) begin
            failures++;
            $display("FAIL model_dut%0d t=%0t got {g,v,id,p}=%b expected %b", k, $time, act, e);
        end
    endtask

    // Starvation tracking for the hold-limited instance during the random phase.
    bit rnd_on = 1'b0;
    int wt[N];

    initial forever begin
        @(negedge clk);
        if (m_ok) begin
            cmp(0, {g_a, v_a, id_a, p_a});
            cmp(1, {g_b, v_b, id_b, p_b});
        end
        if (rnd_on) begin
            int worst;
            worst = 0;
            for (int i = 0; i < N; i++) begin
                if (req[i] && !g_a[i]) wt[i]++;
                else wt[i] = 0;
                if (wt[i] > worst) worst = wt[i];
            end
            checks++;
            if (worst > BOUND) begin
                failures++;
                $display("FAIL starvation t=%0t wait=%0d exceeds bound %0d", $time, worst, BOUND);
            end
        end else begin
            for (int i = 0; i < N; i++) wt[i] = 0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    int order[5] = '{0, 1, 2, 3, 0};
    bit served[N];

    initial begin
        // 1: single requester, grant two edges after req, held without preemption
        do_reset();
        chk("t1_reset", {g_a, v_a, id_a, p_a}, 0);
        req = 4'b0001;
        cyc();
        chk("t1_arb", g_a, 4'b0000);
        cyc();
        chk("t1_grant", {g_a, v_a, id_a}, 7'b0001_1_00);
        repeat (10) begin
            cyc();
            chk("t1_hold", g_a, 4'b0001);
            chk("t1_nopre", p_a, 0);
        end

        // 2: all requesting, each releases after two grant cycles
        do_reset();
        req = 4'b1111;
        cyc();
        chk("t2_first_arb", g_a, 4'b0000);
        cyc();
        for (int s = 0; s < 5; s++) begin
            chk("t2_g1", g_a, 32'(4'b0001 << order[s]));
            cyc();
            chk("t2_g2", g_a, 32'(4'b0001 << order[s]));
            req[order[s]] = 1'b0;
            cyc();
            chk("t2_arb_gap", g_a, 4'b0000);
            req[order[s]] = 1'b1;
            cyc();
        end

        // 3: two requesters held, hold limit forces alternation
        do_reset();
        req = 4'b0011;
        cyc();
        cyc();
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) begin
                chk("t3_hold", g_a, 32'(4'b0001 << r));
                chk("t3_nopre", p_a, 0);
                cyc();
            end
            chk("t3_arb", g_a, 4'b0000);
            chk("t3_preempt", p_a, 1);
            cyc();
        end
        chk("t3_back", g_a, 4'b0001);

        // 4: unlimited hold never rotates
        do_reset();
        req = 4'b0011;
        cyc();
        cyc();
        repeat (200) begin
            chk("t4_hold", g_b, 4'b0001);
            chk("t4_nopre", p_b, 0);
            cyc();
        end

        // 5: reset mid-grant clears outputs and restores last_grant
        do_reset();
        req = 4'b0100;
        cyc();
        cyc();
        chk("t5_pre_grant", g_a, 4'b0100);
        reset = 1'b1;
        req   = 4'b1100;
        cyc();
        chk("t5_reset_out", {g_a, v_a, id_a, p_a}, 0);
        reset = 1'b0;
        cyc();
        chk("t5_arb", g_a, 4'b0000);
        cyc();
        chk("t5_win", {g_a, id_a}, 6'b0100_10);

        // 6: random traffic, unserved requests held
        do_reset();
        for (int i = 0; i < N; i++) served[i] = 1'b0;
        rnd_on = 1'b1;
        repeat (10000) begin
            logic [N-1:0] nr;
            nr = req;
            for (int i = 0; i < N; i++) begin
                if (g_a[i]) begin
                    served[i] = 1'b1;
                    if ($urandom_range(0, 2) == 0) nr[i] = 1'b0;
                end else if (req[i]) begin
                    if (served[i] && $urandom_range(0, 3) == 0) nr[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    nr[i] = 1'b1;
                end
                if (!nr[i]) served[i] = 1'b0;
            end
            req = nr;
            cyc();
        end
        rnd_on = 1'b0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
